keypad_entry: RTL and testbench

- Sits directly downstream of the keypad scanner/debouncer stage and consumes its 4-bit key code and key-pressed indication.
- Validates each press, generates exactly one event per physical press, and turns key presses into a multi-digit decimal operand.
- Digits accumulate in BCD (for the 7-segment display path) and in binary (for arithmetic).
- '*' clears the entry; '#' commits the entry as an operand with a one-cycle valid pulse.

---
 rtl/keypad_entry.sv | 161 ++++++++++++++++
 tb/tb_keypad_entry.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Keypad press validator and decimal operand builder: one event per physical
// press, BCD + binary digit accumulation, '*' clears, '#' commits the operand.
module keypad_entry #(
    parameter int STABLE_CYCLES  = 27_000,
    parameter int RELEASE_CYCLES = 27_000,
    parameter int NUM_DIGITS     = 3,
    parameter int BIN_W          = 10
) (
    input  logic                              clk,
    input  logic                              n_reset,
    input  logic [3:0]                        key_code,
    input  logic                              key_pressed,
    output logic                              key_event,
    output logic [3:0]                        key_last,
    output logic [4*NUM_DIGITS-1:0]           digits_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              overflow,
    output logic [BIN_W-1:0]                  operand,
    output logic                              operand_valid
);

    localparam int CMAX = (STABLE_CYCLES > RELEASE_CYCLES) ? STABLE_CYCLES : RELEASE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int DW   = $clog2(NUM_DIGITS + 1);
    localparam int BW   = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] STAB   = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] REL    = CW'(RELEASE_CYCLES);
    localparam logic [DW-1:0] MAXD   = DW'(NUM_DIGITS);
    localparam logic [3:0]    KEY_CLR = 4'hD;
    localparam logic [3:0]    KEY_ENT = 4'hE;

    typedef enum logic [1:0] {IDLE, STABLE, ACCEPT, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        cand_q, cand_d;
    logic              event_q, event_d;
    logic              valid_q, valid_d;
    logic [3:0]        last_q, last_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic              ovf_q, ovf_d;
    logic [BIN_W-1:0]  opnd_q, opnd_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        event_d = 1'b0;
        valid_d = 1'b0;
        last_d  = last_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        dcnt_d  = dcnt_q;
        ovf_d   = ovf_q;
        opnd_d  = opnd_q;

        case (state_q)
            IDLE: begin
                if (key_pressed) begin
                    cand_d  = key_code;
                    cnt_d   = CW'(1);
                    state_d = (cnt_d == STAB) ? ACCEPT : STABLE;
                end
            end
            STABLE: begin
                if (!key_pressed) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (key_code != cand_q) begin
                        cand_d = key_code;
                        cnt_d  = CW'(1);
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                    end
                    if (cnt_d == STAB) state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                event_d = 1'b1;
                last_d  = cand_q;
                cnt_d   = '0;
                state_d = RELEASE;
                if (cand_q <= 4'd9) begin
                    if (dcnt_q < MAXD) begin
                        // Widening concat then truncating drops the oldest digit slot.
                        bcd_d  = BW'({bcd_q, cand_q});
                        bin_d  = bin_q * BIN_W'(10) + BIN_W'(cand_q);
                        dcnt_d = dcnt_q + DW'(1);
                    end else begin
                        ovf_d  = 1'b1;
                    end
                end else if (cand_q == KEY_CLR) begin
                    bcd_d  = '0;
                    bin_d  = '0;
                    dcnt_d = '0;
                    ovf_d  = 1'b0;
                end else if (cand_q == KEY_ENT && dcnt_q != '0) begin
                    opnd_d  = bin_q;
                    valid_d = 1'b1;
                    bcd_d   = '0;
                    bin_d   = '0;
                    dcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            RELEASE: begin
                // Holding or re-pressing restarts the quiet window; no auto-repeat.
                cnt_d = key_pressed ? '0 : cnt_q + CW'(1);
                if (cnt_d == REL) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            event_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            dcnt_q  <= '0;
            ovf_q   <= 1'b0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            event_q <= event_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            dcnt_q  <= dcnt_d;
            ovf_q   <= ovf_d;
            opnd_q  <= opnd_d;
        end
    end

    assign key_event     = event_q;
    assign operand_valid = valid_q;
    assign key_last      = last_q;
    assign digits_bcd    = bcd_q;
    assign digit_count   = dcnt_q;
    assign overflow      = ovf_q;
    assign operand       = opnd_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboarded bench for keypad_entry with short stability/release windows.
module tb_keypad_entry;

    localparam int S = 4;
    localparam int R = 4;

    logic        clk;
    logic        n_reset;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic        key_event;
    logic [3:0]  key_last;
    logic [11:0] digits_bcd;
    logic [1:0]  digit_count;
    logic        overflow;
    logic [9:0]  operand;
    logic        operand_valid;

    keypad_entry #(.STABLE_CYCLES(S), .RELEASE_CYCLES(R), .NUM_DIGITS(3), .BIN_W(10)) dut (
        .clk(clk), .n_reset(n_reset), .key_code(key_code), .key_pressed(key_pressed),
        .key_event(key_event), .key_last(key_last), .digits_bcd(digits_bcd),
        .digit_count(digit_count), .overflow(overflow), .operand(operand),
        .operand_valid(operand_valid)
    );

    typedef struct packed {
        logic [3:0]  key;
        logic [11:0] bcd;
        logic [1:0]  cnt;
        logic        ovf;
        logic        vld;
        logic [9:0]  opnd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_events = 0;

    logic [11:0] m_bcd;
    int          m_bin;
    int          m_cnt;
    logic        m_ovf;
    int          m_opnd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_bcd = '0; m_bin = 0; m_cnt = 0; m_ovf = 1'b0; m_opnd = 0;
    endtask

    // Expected outputs of one accepted press, from an arithmetic model of the entry.
    task automatic push_press(input logic [3:0] k);
        exp_t e;
        logic v;
        v = 1'b0;
        if (k <= 4'd9) begin
            if (m_cnt < 3) begin
                m_bcd = {m_bcd[7:0], k};
                m_bin = m_bin * 10 + int'(k);
                m_cnt++;
            end else m_ovf = 1'b1;
        end else if (k == 4'hD) begin
            m_bcd = '0; m_bin = 0; m_cnt = 0; m_ovf = 1'b0;
        end else if (k == 4'hE && m_cnt > 0) begin
            m_opnd = m_bin; v = 1'b1;
            m_bcd = '0; m_bin = 0; m_cnt = 0; m_ovf = 1'b0;
        end
        e.key = k; e.bcd = m_bcd; e.cnt = 2'(m_cnt); e.ovf = m_ovf; e.vld = v; e.opnd = 10'(m_opnd);
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        logic pe = 1'b0;
        logic pv = 1'b0;
        forever begin
            @(negedge clk);
            if (key_event) begin
                n_checks++; n_events++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL event_unexpected key_last=%h, no event required", key_last);
                end else begin
                    e = sb.pop_front();
                    if ({key_last, digits_bcd, digit_count, overflow, operand_valid, operand} !== e) begin
                        n_fail++;
                        $display("FAIL event_outputs got key=%h bcd=%h cnt=%0d ovf=%b vld=%b opnd=%0d, want key=%h bcd=%h cnt=%0d ovf=%b vld=%b opnd=%0d",
                                 key_last, digits_bcd, digit_count, overflow, operand_valid, operand,
                                 e.key, e.bcd, e.cnt, e.ovf, e.vld, e.opnd);
                    end
                end
            end else if (operand_valid) begin
                n_checks++; n_fail++;
                $display("FAIL valid_without_event operand_valid=1, want 0");
            end
            if (key_event || operand_valid) begin
                n_checks++;
                if ((key_event && pe) || (operand_valid && pv)) begin
                    n_fail++;
                    $display("FAIL pulse_width key_event=%b/%b valid=%b/%b, want no back-to-back pulses",
                             pe, key_event, pv, operand_valid);
                end
            end
            pe = key_event; pv = operand_valid;
            assert (dut.bin_q <= 10'd999) else $error("binary accumulator wrapped: %0d", dut.bin_q);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        @(negedge clk);
        key_code = k; key_pressed = 1'b1;
        if (hold >= S) push_press(k);
        repeat (hold) @(negedge clk);
        key_pressed = 1'b0;
        repeat (R + 2) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s pending_events=%0d, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({key_event, key_last, digits_bcd, digit_count, overflow, operand, operand_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_state ev=%b last=%h bcd=%h cnt=%0d ovf=%b opnd=%0d vld=%b, want all 0",
                     key_event, key_last, digits_bcd, digit_count, overflow, operand, operand_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        key_code = 4'h7; key_pressed = 1'b1;
        push_press(4'h7);
        repeat (S) @(posedge clk);
        #1;
        n_checks++;
        if (key_event !== 1'b0) begin
            n_fail++; $display("FAIL latency_early key_event=%b, want 0", key_event);
        end
        @(posedge clk); #1;
        n_checks++;
        if (key_event !== 1'b1) begin
            n_fail++; $display("FAIL latency_event key_event=%b, want 1", key_event);
        end
        repeat (10 - S - 1) @(posedge clk);
        @(negedge clk);
        key_pressed = 1'b0;
        repeat (R + 2) @(negedge clk);
        check_drained("single_press");
        n_checks++;
        if ({key_last, digits_bcd, digit_count} !== {4'h7, 12'h007, 2'd1}) begin
            n_fail++;
            $display("FAIL single_press last=%h bcd=%h cnt=%0d, want 7 007 1", key_last, digits_bcd, digit_count);
        end
    endtask

    task automatic test_commit();
        press(4'hD, 5);
        press(4'h1, 5); press(4'h2, 6); press(4'h3, 8);
        n_checks++;
        if (digits_bcd !== 12'h123) begin
            n_fail++; $display("FAIL pre_commit_bcd got %h, want 123", digits_bcd);
        end
        press(4'hE, 5);
        check_drained("commit");
        n_checks++;
        if (operand !== 10'd123 || digit_count !== 2'd0 || digits_bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL commit_result opnd=%0d cnt=%0d bcd=%h, want 123 0 000", operand, digit_count, digits_bcd);
        end
    endtask

    task automatic test_overflow();
        press(4'h9, 4); press(4'h9, 4); press(4'h9, 4); press(4'h5, 4);
        n_checks++;
        if (digits_bcd !== 12'h999 || overflow !== 1'b1 || digit_count !== 2'd3) begin
            n_fail++;
            $display("FAIL overflow bcd=%h ovf=%b cnt=%0d, want 999 1 3", digits_bcd, overflow, digit_count);
        end
        press(4'hD, 4);
        check_drained("overflow");
        n_checks++;
        if (digits_bcd !== 12'h000 || overflow !== 1'b0 || operand !== 10'd123) begin
            n_fail++;
            $display("FAIL clear bcd=%h ovf=%b opnd=%0d, want 000 0 123", digits_bcd, overflow, operand);
        end
    endtask

    task automatic test_code_change();
        int n0;
        @(negedge clk);
        key_code = 4'h3; key_pressed = 1'b1;
        repeat (2) @(negedge clk);
        key_code = 4'h4;
        push_press(4'h4);
        repeat (4) @(negedge clk);
        key_pressed = 1'b0;
        repeat (R + 2) @(negedge clk);
        check_drained("code_change");
        n_checks++;
        if (key_last !== 4'h4 || digits_bcd !== 12'h004) begin
            n_fail++; $display("FAIL code_change last=%h bcd=%h, want 4 004", key_last, digits_bcd);
        end
        n0 = n_events;
        press(4'h5, 3);
        n_checks++;
        if (n_events !== n0 || digits_bcd !== 12'h004) begin
            n_fail++;
            $display("FAIL glitch events=%0d bcd=%h, want %0d 004", n_events, digits_bcd, n0);
        end
    endtask

    task automatic test_bounce();
        int n0;
        press(4'hD, 4);
        n0 = n_events;
        @(negedge clk);
        key_code = 4'hB; key_pressed = 1'b1;
        push_press(4'hB);
        repeat (6) @(negedge clk);
        key_pressed = 1'b0;
        repeat (2) @(negedge clk);
        key_code = 4'h2; key_pressed = 1'b1;
        repeat (6) @(negedge clk);
        key_pressed = 1'b0;
        repeat (R + 2) @(negedge clk);
        n_checks++;
        if (n_events !== n0 + 1 || key_last !== 4'hB || digit_count !== 2'd0) begin
            n_fail++;
            $display("FAIL bounce events=%0d last=%h cnt=%0d, want %0d B 0", n_events, key_last, digit_count, n0 + 1);
        end
        press(4'hE, 5);
        check_drained("empty_enter");
        n_checks++;
        if (operand !== 10'd123 || key_last !== 4'hE) begin
            n_fail++; $display("FAIL empty_enter opnd=%0d last=%h, want 123 E", operand, key_last);
        end
    endtask

    task automatic test_async_reset();
        press(4'h4, 5); press(4'h5, 5);
        @(negedge clk);
        key_code = 4'h6; key_pressed = 1'b1;
        @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        sb.delete();
        model_reset();
        n_checks++;
        if ({key_event, key_last, digits_bcd, digit_count, overflow, operand, operand_valid} !== '0) begin
            n_fail++;
            $display("FAIL async_reset last=%h bcd=%h cnt=%0d ovf=%b opnd=%0d, want all 0",
                     key_last, digits_bcd, digit_count, overflow, operand);
        end
        @(negedge clk);
        key_pressed = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        press(4'h7, 5);
        check_drained("after_reset");
        n_checks++;
        if (digits_bcd !== 12'h007 || digit_count !== 2'd1) begin
            n_fail++; $display("FAIL fresh_entry bcd=%h cnt=%0d, want 007 1", digits_bcd, digit_count);
        end
    endtask

    initial begin
        n_reset = 1'b0; key_pressed = 1'b0; key_code = 4'h0;
        model_reset();
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        test_reset();
        n_reset = 1'b1;
        test_single();
        test_commit();
        test_overflow();
        test_code_change();
        test_bounce();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
